// File: rtl/frame_strobe_ctrl.sv
// Frame configuration sequencer: takes a header word and a burst of frame data words,
// and issues one registered one-hot FrameStrobe per word to the tile column.
//
// state  | meaning
// IDLE   | waiting for a header word
// DATA   | waiting for the next frame data word
// SETUP  | FrameData settled, strobe still low
// STROBE | one-hot strobe on frame idx
// HOLD   | strobe low, FrameData held; advance or finish
module frame_strobe_ctrl #(
  parameter int MaxFramesPerCol = 32,
  parameter int FrameBitsPerRow = 32
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic [31:0]                s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       err_clr,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       err,
  output logic [15:0]                frames_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    SETUP  = 3'd2,
    STROBE = 3'd3,
    HOLD   = 3'd4
  } state_t;

  localparam logic [31:0] LastIdx = 32'(MaxFramesPerCol - 1);

  state_t                     state_q, state_d;
  logic [4:0]                 idx_q, idx_d;
  logic [4:0]                 rem_q, rem_d;
  logic [FrameBitsPerRow-1:0] data_q, data_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
  logic                       err_q, err_d;
  logic [15:0]                done_q, done_d;

  logic [5:0] hdr_sum;
  logic       hdr_ok;

  // Range check uses the full 6-bit sum so S+N overflowing 5 bits is still rejected.
  assign hdr_sum = {1'b0, s_data[12:8]} + {1'b0, s_data[4:0]};
  assign hdr_ok  = (s_data[31:16] == 16'hFAB0) && ({26'd0, hdr_sum} <= LastIdx);

  assign s_ready     = (state_q == IDLE) || (state_q == DATA);
  assign busy        = (state_q != IDLE);
  assign FrameData   = data_q;
  assign FrameStrobe = strobe_q;
  assign err         = err_q;
  assign frames_done = done_q;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      rem_q    <= '0;
      data_q   <= '0;
      strobe_q <= '0;
      err_q    <= 1'b0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rem_q    <= rem_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rem_d    = rem_q;
    data_d   = data_q;
    strobe_d = '0;
    err_d    = err_q;
    done_d   = done_q;

    // A header error in the same cycle overrides the clear below.
    if (err_clr) err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (s_valid) begin
          if (hdr_ok) begin
            idx_d   = s_data[4:0];
            rem_d   = s_data[12:8];
            state_d = DATA;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (s_valid) begin
          data_d  = s_data[FrameBitsPerRow-1:0];
          state_d = SETUP;
        end
      end
      SETUP: begin
        // Strobe is registered here so it is high exactly during STROBE.
        strobe_d = MaxFramesPerCol'(1) << idx_q;
        state_d  = STROBE;
      end
      STROBE: begin
        done_d  = done_q + 16'd1;
        state_d = HOLD;
      end
      HOLD: begin
        if (rem_q == 5'd0) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 5'd1;
          rem_d   = rem_q - 5'd1;
          state_d = DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_frame_strobe_ctrl.sv
// Directed bench for frame_strobe_ctrl: header/data bursts, error flag, stalls,
// mid-burst reset and frames_done wrap, each checked with immediate assertions.
module tb_frame_strobe_ctrl;

  logic        CLK;
  logic        resetn;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        err_clr;
  logic [31:0] FrameData;
  logic [31:0] FrameStrobe;
  logic        busy;
  logic        err;
  logic [15:0] frames_done;

  int checks = 0;
  int errors = 0;

  frame_strobe_ctrl #(
    .MaxFramesPerCol(32),
    .FrameBitsPerRow(32)
  ) dut (
    .CLK        (CLK),
    .resetn     (resetn),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .err_clr    (err_clr),
    .FrameData  (FrameData),
    .FrameStrobe(FrameStrobe),
    .busy       (busy),
    .err        (err),
    .frames_done(frames_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present a word, wait (bounded) for s_ready, let it transfer on the next edge.
  task automatic send(input logic [31:0] w);
    int n;
    s_data  = w;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 20) begin
      step();
      n++;
    end
    if (!s_ready) chk("ready_timeout", {31'd0, s_ready}, 32'd1);
    step();
    s_valid = 1'b0;
  endtask

  initial begin
    resetn  = 1'b0;
    s_data  = '0;
    s_valid = 1'b0;
    err_clr = 1'b0;
    #2;
    chk("rst_strobe", FrameStrobe, 32'h0);
    chk("rst_data", FrameData, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_done", {16'd0, frames_done}, 32'd0);
    step();
    step();
    @(negedge CLK);
    resetn = 1'b1;
    step();
    chk("ready_after_rst", {31'd0, s_ready}, 32'd1);

    // Single frame: S=3, N=0
    send(32'hFAB0_0003);
    chk("t1_busy_data", {31'd0, busy}, 32'd1);
    send(32'hDEAD_BEEF);
    chk("t1_setup_data", FrameData, 32'hDEAD_BEEF);
    chk("t1_setup_strobe", FrameStrobe, 32'h0);
    chk("t1_setup_ready", {31'd0, s_ready}, 32'd0);
    step();
    chk("t1_strobe", FrameStrobe, 32'h0000_0008);
    step();
    chk("t1_hold_strobe", FrameStrobe, 32'h0);
    chk("t1_hold_data", FrameData, 32'hDEAD_BEEF);
    chk("t1_done", {16'd0, frames_done}, 32'd1);
    step();
    chk("t1_idle_ready", {31'd0, s_ready}, 32'd1);
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);

    // Three frames ending on the last legal index: S=29, N=2
    send(32'hFAB0_021D);
    send(32'd1);
    step();
    chk("t2_strobe29", FrameStrobe, 32'h2000_0000);
    chk("t2_data1", FrameData, 32'd1);
    step();
    step();
    chk("t2_back_to_data", {31'd0, s_ready}, 32'd1);
    send(32'd2);
    step();
    chk("t2_strobe30", FrameStrobe, 32'h4000_0000);
    chk("t2_data2", FrameData, 32'd2);
    step();
    step();
    send(32'd3);
    step();
    chk("t2_strobe31", FrameStrobe, 32'h8000_0000);
    chk("t2_data3", FrameData, 32'd3);
    step();
    step();
    chk("t2_idle_busy", {31'd0, busy}, 32'd0);
    chk("t2_done", {16'd0, frames_done}, 32'd4);
    chk("t2_no_err", {31'd0, err}, 32'd0);

    // Range overflow (30+3), bad sync, clear, and clear colliding with a new error
    send(32'hFAB0_031E);
    chk("t3_err_range", {31'd0, err}, 32'd1);
    chk("t3_idle", {31'd0, busy}, 32'd0);
    chk("t3_ready", {31'd0, s_ready}, 32'd1);
    chk("t3_no_strobe", FrameStrobe, 32'h0);
    send(32'h1234_0000);
    chk("t3_err_sync", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t3_err_cleared", {31'd0, err}, 32'd0);
    err_clr = 1'b1;
    send(32'h0000_0000);
    err_clr = 1'b0;
    chk("t3_set_wins", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t3_err_cleared2", {31'd0, err}, 32'd0);
    chk("t3_done_same", {16'd0, frames_done}, 32'd4);

    // Stall in DATA for 10 cycles mid-burst: S=2, N=1
    send(32'hFAB0_0102);
    send(32'h0000_00AA);
    step();
    chk("t4_strobe2", FrameStrobe, 32'h0000_0004);
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      chk("t4_stall_strobe", FrameStrobe, 32'h0);
      chk("t4_stall_busy", {31'd0, busy}, 32'd1);
      step();
    end
    send(32'h0000_00BB);
    step();
    chk("t4_strobe3", FrameStrobe, 32'h0000_0008);
    chk("t4_data", FrameData, 32'h0000_00BB);
    step();
    step();
    chk("t4_done", {16'd0, frames_done}, 32'd6);
    chk("t4_idle", {31'd0, busy}, 32'd0);

    // Reset during STROBE of index 5
    send(32'hFAB0_0005);
    send(32'h0000_0055);
    step();
    chk("t5_strobe5", FrameStrobe, 32'h0000_0020);
    #2;
    resetn = 1'b0;
    #1;
    chk("t5_rst_strobe", FrameStrobe, 32'h0);
    chk("t5_rst_data", FrameData, 32'h0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_done", {16'd0, frames_done}, 32'd0);
    @(negedge CLK);
    resetn = 1'b1;
    step();
    chk("t5_ready", {31'd0, s_ready}, 32'd1);
    send(32'hFAB0_0000);
    send(32'h0000_0077);
    step();
    chk("t5_strobe0", FrameStrobe, 32'h0000_0001);
    step();
    step();
    chk("t5_done", {16'd0, frames_done}, 32'd1);

    // frames_done wrap: preload to FFFF while idle, then one more frame
    force dut.done_q = 16'hFFFF;
    #1;
    release dut.done_q;
    #1;
    chk("t6_preload", {16'd0, frames_done}, 32'h0000_FFFF);
    send(32'hFAB0_0000);
    send(32'h0000_0001);
    step();
    step();
    chk("t6_wrap", {16'd0, frames_done}, 32'h0);
    step();
    chk("t6_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/frame_strobe_ctrl.md
FRAME_STROBE_CTRL -- requirements
Module: frame_strobe_ctrl

Interface
REQ-001 Parameter MaxFramesPerCol, default 32: FrameStrobe width; legal frame indices are 0..MaxFramesPerCol-1.
REQ-002 Parameter FrameBitsPerRow, default 32: FrameData width; low FrameBitsPerRow bits of each data word are used.
REQ-003 CLK  input  1  configuration clock; all state updates on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 s_data  input  32  configuration word (header or frame data).
REQ-006 s_valid  input  1  s_data valid; word transfers on a rising edge with s_valid=1 and s_ready=1.
REQ-007 s_ready  output  1  block accepts a word this cycle.
REQ-008 err_clr  input  1  synchronous clear of err.
REQ-009 FrameData  output  FrameBitsPerRow  frame data bus to the tile column.
REQ-010 FrameStrobe  output  MaxFramesPerCol  one-hot frame write strobe to the tile column.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 err  output  1  sticky header error flag.
REQ-013 frames_done  output  16  count of strobes issued since reset.

Function
REQ-014 Header word: [31:16] sync, SHALL equal 16'hFAB0; [12:8] count N; [4:0] start index S; all other bits ignored; burst length is N+1 frames.
REQ-015 States: IDLE, DATA, SETUP, STROBE, HOLD; combinational s_ready=1 only in IDLE and DATA.
REQ-016 IDLE, header accepted, sync valid and S+N <= MaxFramesPerCol-1 (6-bit sum, no truncation): load idx=S, remaining=N, go DATA.
REQ-017 IDLE, header accepted with bad sync or S+N > MaxFramesPerCol-1: set err, discard word, remain IDLE.
REQ-018 DATA, word accepted: FrameData <= s_data[FrameBitsPerRow-1:0]; go SETUP; no handshake -> remain DATA indefinitely.
REQ-019 SETUP lasts exactly one cycle, FrameStrobe all-zero, then STROBE.
REQ-020 STROBE lasts exactly one cycle: FrameStrobe = one-hot bit idx, frames_done increments by 1 (wraps 16'hFFFF -> 0); then HOLD.
REQ-021 HOLD lasts one cycle, FrameStrobe all-zero; remaining==0 -> IDLE; else idx+1, remaining-1, -> DATA.
REQ-022 Latency: data accepted at edge k -> SETUP in cycle k+1, FrameStrobe high in cycle k+2 only, HOLD k+3, s_ready high again in cycle k+4; 4 cycles per frame minimum.
REQ-023 FrameData SHALL be stable from SETUP through HOLD and hold its value until the next data load.
REQ-024 FrameStrobe SHALL never have more than one bit set and SHALL be registered (glitch-free).
REQ-025 err_clr clears err next edge; err_clr and a new error in the same cycle -> err set wins; err never alters state flow.
REQ-026 s_valid with s_ready=0 SHALL be ignored (word neither consumed nor lost from source; source holds it).

Reset
REQ-027 resetn low SHALL immediately force IDLE, FrameStrobe=0, FrameData=0, err=0, frames_done=0, busy=0, idx=0, remaining=0, independent of CLK.
REQ-028 Reset asserted mid-burst (including during STROBE) SHALL drop FrameStrobe at once and abandon the burst; after release the block expects a header.
REQ-029 s_ready SHALL be 1 in the first cycle after resetn deasserts.

Verification
REQ-030 Header 32'hFAB0_0003, data 32'hDEAD_BEEF -> FrameData=32'hDEADBEEF from SETUP on, FrameStrobe=32'h0000_0008 for exactly one cycle two cycles after data edge, frames_done=1, IDLE after HOLD.
REQ-031 Header 32'hFAB0_021D (S=29, N=2), data words 1,2,3 -> strobes bits 29,30,31 in order with FrameData 1,2,3 respectively; frames_done=3; no err.
REQ-032 Header 32'hFAB0_031E (S=30, N=3, overflow) -> err=1, no strobe, s_ready stays 1; then header 32'h1234_0000 -> err remains 1; err_clr pulse -> err=0.
REQ-033 Burst in progress, s_valid held low 10 cycles in DATA -> FrameStrobe stays 0, busy=1; resume -> next strobe index continues correctly.
REQ-034 resetn pulsed low during STROBE of index 5 -> FrameStrobe=0 and FrameData=0 before next CLK edge; after release header 32'hFAB0_0000 plus data -> normal single strobe on bit 0.
REQ-035 Preload frames_done to 16'hFFFF via 65535 single-frame writes, one more -> frames_done=0.
